// File: rtl/cvxif_router_pkg.sv
// Shared types and helpers for the multi-coprocessor CVXIF router.
package cvxif_router_pkg;

  localparam int MaxCopro   = 8;
  localparam int OwnerWidth = $clog2(MaxCopro);

  // One scoreboard slot per instruction ID: which coprocessor owes the result.
  typedef struct packed {
    logic                  valid;
    logic [OwnerWidth-1:0] owner;
  } sb_entry_t;

  function automatic logic [OwnerWidth-1:0] lowest_set(input logic [MaxCopro-1:0] vec);
    logic [OwnerWidth-1:0] idx;
    idx = '0;
    for (int i = MaxCopro - 1; i >= 0; i--) begin
      if (vec[i]) idx = OwnerWidth'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/cvxif_copro_router_if.sv
// Core-side and coprocessor-side signal bundle of the CVXIF router.
interface cvxif_copro_router_if #(
  parameter int NumCopro   = 2,
  parameter int IdWidth    = 3,
  parameter int XLEN       = 64,
  parameter int InstrWidth = 32
);
  // Handshakes: a transfer occurs on a rising edge where valid and ready are both
  // high; a raised valid keeps its payload stable until that transfer happens.
  logic                       flush_i;
  logic                       issue_valid_i;
  logic                       issue_ready_o;
  logic [IdWidth-1:0]         issue_id_i;
  logic [InstrWidth-1:0]      issue_instr_i;
  logic                       issue_accept_o;
  logic                       issue_writeback_o;
  logic [NumCopro-1:0]        cp_issue_valid_o;
  logic [NumCopro-1:0]        cp_issue_ready_i;
  logic [IdWidth-1:0]         cp_issue_id_o;
  logic [InstrWidth-1:0]      cp_issue_instr_o;
  logic [NumCopro-1:0]        cp_issue_accept_i;
  logic [NumCopro-1:0]        cp_issue_writeback_i;
  logic [NumCopro-1:0]        cp_result_valid_i;
  logic [NumCopro-1:0]        cp_result_ready_o;
  logic [NumCopro*IdWidth-1:0] cp_result_id_i;
  logic [NumCopro*XLEN-1:0]   cp_result_data_i;
  logic                       result_valid_o;
  logic                       result_ready_i;
  logic [IdWidth-1:0]         result_id_o;
  logic [XLEN-1:0]            result_data_o;
  logic                       multi_accept_o;
  logic                       stray_o;
  logic                       busy_o;
  logic [NumCopro*32-1:0]     perf_issued_o;
  logic [31:0]                perf_stray_o;

  modport slave (
    input  flush_i, issue_valid_i, issue_id_i, issue_instr_i,
           cp_issue_ready_i, cp_issue_accept_i, cp_issue_writeback_i,
           cp_result_valid_i, cp_result_id_i, cp_result_data_i, result_ready_i,
    output issue_ready_o, issue_accept_o, issue_writeback_o,
           cp_issue_valid_o, cp_issue_id_o, cp_issue_instr_o, cp_result_ready_o,
           result_valid_o, result_id_o, result_data_o,
           multi_accept_o, stray_o, busy_o, perf_issued_o, perf_stray_o
  );

  modport master (
    output flush_i, issue_valid_i, issue_id_i, issue_instr_i,
           cp_issue_ready_i, cp_issue_accept_i, cp_issue_writeback_i,
           cp_result_valid_i, cp_result_id_i, cp_result_data_i, result_ready_i,
    input  issue_ready_o, issue_accept_o, issue_writeback_o,
           cp_issue_valid_o, cp_issue_id_o, cp_issue_instr_o, cp_result_ready_o,
           result_valid_o, result_id_o, result_data_o,
           multi_accept_o, stray_o, busy_o, perf_issued_o, perf_stray_o
  );
endinterface

// File: rtl/cvxif_result_arbiter.sv
// Result side: classifies returning results, round-robin picks one into a
// registered output. Stray counter exists only with CVXIF_ROUTER_PERF_EN.
module cvxif_result_arbiter
  import cvxif_router_pkg::*;
#(
  parameter int NumCopro = 2,
  parameter int IdWidth  = 3,
  parameter int XLEN     = 64
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          flush_i,
  input  sb_entry_t [2**IdWidth-1:0]    sb_i,
  input  logic [NumCopro-1:0]           cp_result_valid_i,
  input  logic [NumCopro*IdWidth-1:0]   cp_result_id_i,
  input  logic [NumCopro*XLEN-1:0]      cp_result_data_i,
  output logic [NumCopro-1:0]           cp_result_ready_o,
  output logic                          result_valid_o,
  input  logic                          result_ready_i,
  output logic [IdWidth-1:0]            result_id_o,
  output logic [XLEN-1:0]               result_data_o,
  output logic                          clr_valid_o,
  output logic [IdWidth-1:0]            clr_id_o,
  output logic                          stray_o,
  output logic [31:0]                   perf_stray_o
);

  logic [NumCopro-1:0]   cand, stray, grant_vec;
  logic [2*NumCopro-1:0] cand_rot;
  logic [IdWidth-1:0]    lane_id, sel_id;
  logic [XLEN-1:0]       sel_data;
  logic [OwnerWidth-1:0] ptr_q, ptr_nxt, win;
  logic                  found, load_en, stray_q;
  int                    w, pn;

  always_comb begin
    cand    = '0;
    lane_id = '0;
    for (int i = 0; i < NumCopro; i++) begin
      lane_id = cp_result_id_i[i*IdWidth +: IdWidth];
      cand[i] = cp_result_valid_i[i] && sb_i[lane_id].valid &&
                (sb_i[lane_id].owner == OwnerWidth'(i));
    end
    stray = cp_result_valid_i & ~cand;
  end

  // Loading is suppressed during flush so no result is handed over only to be killed.
  assign load_en = (!result_valid_o || result_ready_i) && !flush_i;

  always_comb begin
    cand_rot = {cand, cand} >> ptr_q;
    found    = 1'b0;
    w        = 0;
    for (int k = 0; k < NumCopro; k++) begin
      if (!found && cand_rot[k]) begin
        found = 1'b1;
        w     = int'(ptr_q) + k;
      end
    end
    if (w >= NumCopro) w = w - NumCopro;
    pn = w + 1;
    if (pn >= NumCopro) pn = 0;
    win     = OwnerWidth'(w);
    ptr_nxt = OwnerWidth'(pn);
  end

  always_comb begin
    sel_id    = '0;
    sel_data  = '0;
    grant_vec = '0;
    for (int i = 0; i < NumCopro; i++) begin
      if (found && win == OwnerWidth'(i)) begin
        sel_id       = cp_result_id_i[i*IdWidth +: IdWidth];
        sel_data     = cp_result_data_i[i*XLEN +: XLEN];
        grant_vec[i] = load_en;
      end
    end
  end

  assign cp_result_ready_o = stray | grant_vec;
  assign clr_valid_o       = load_en && found;
  assign clr_id_o          = sel_id;
  assign stray_o           = stray_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      result_valid_o <= 1'b0;
      result_id_o    <= '0;
      result_data_o  <= '0;
      ptr_q          <= '0;
      stray_q        <= 1'b0;
    end else begin
      stray_q <= |stray;
      if (flush_i) begin
        result_valid_o <= 1'b0;
      end else if (load_en) begin
        result_valid_o <= found;
        if (found) begin
          result_id_o   <= sel_id;
          result_data_o <= sel_data;
          ptr_q         <= ptr_nxt;
        end
      end
    end
  end

`ifdef CVXIF_ROUTER_PERF_EN
  logic [31:0] stray_cnt_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) stray_cnt_q <= '0;
    else         stray_cnt_q <= stray_cnt_q + 32'($countones(stray));
  end
  assign perf_stray_o = stray_cnt_q;
`else
  assign perf_stray_o = '0;
`endif

endmodule

// File: rtl/cvxif_copro_router.sv
// CVXIF router: broadcasts issues to NumCopro coprocessors, tracks ID owners,
// arbitrates results back. Performance counters need CVXIF_ROUTER_PERF_EN.
module cvxif_copro_router
  import cvxif_router_pkg::*;
#(
  parameter int NumCopro   = 2,
  parameter int IdWidth    = 3,
  parameter int XLEN       = 64,
  parameter int InstrWidth = 32
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  cvxif_copro_router_if.slave bus
);

  localparam int Depth = 2**IdWidth;

  sb_entry_t [Depth-1:0] sb_q;
  logic [MaxCopro-1:0]   accept_pad, wb_pad;
  logic [OwnerWidth-1:0] issue_winner;
  logic                  issue_ok, issue_hs, record, multi_q, busy;
  logic                  clr_valid;
  logic [IdWidth-1:0]    clr_id;

  always_comb begin
    accept_pad                 = '0;
    wb_pad                     = '0;
    accept_pad[NumCopro-1:0]   = bus.cp_issue_accept_i;
    wb_pad[NumCopro-1:0]       = bus.cp_issue_writeback_i;
  end

  // An ID may only be reissued once its previous result has been loaded.
  assign issue_ok              = !sb_q[bus.issue_id_i].valid && !bus.flush_i;
  assign bus.cp_issue_valid_o  = {NumCopro{bus.issue_valid_i && issue_ok}};
  assign bus.issue_ready_o     = (&bus.cp_issue_ready_i) && issue_ok;
  assign bus.cp_issue_id_o     = bus.issue_id_i;
  assign bus.cp_issue_instr_o  = bus.issue_instr_i;
  assign issue_winner          = lowest_set(accept_pad);
  assign bus.issue_accept_o    = |bus.cp_issue_accept_i;
  assign bus.issue_writeback_o = bus.issue_accept_o && wb_pad[issue_winner];
  assign issue_hs              = bus.issue_valid_i && bus.issue_ready_o;
  assign record                = issue_hs && bus.issue_writeback_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sb_q    <= '0;
      multi_q <= 1'b0;
    end else begin
      multi_q <= issue_hs && ($countones(bus.cp_issue_accept_i) > 1);
      if (bus.flush_i) begin
        sb_q <= '0;
      end else begin
        if (clr_valid) sb_q[clr_id].valid <= 1'b0;
        if (record)    sb_q[bus.issue_id_i] <= sb_entry_t'{valid: 1'b1, owner: issue_winner};
      end
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int d = 0; d < Depth; d++) busy = busy | sb_q[d].valid;
  end

  assign bus.busy_o         = busy;
  assign bus.multi_accept_o = multi_q;

  cvxif_result_arbiter #(
    .NumCopro (NumCopro),
    .IdWidth  (IdWidth),
    .XLEN     (XLEN)
  ) u_result_arbiter (
    .clk_i             (clk_i),
    .rst_ni            (rst_ni),
    .flush_i           (bus.flush_i),
    .sb_i              (sb_q),
    .cp_result_valid_i (bus.cp_result_valid_i),
    .cp_result_id_i    (bus.cp_result_id_i),
    .cp_result_data_i  (bus.cp_result_data_i),
    .cp_result_ready_o (bus.cp_result_ready_o),
    .result_valid_o    (bus.result_valid_o),
    .result_ready_i    (bus.result_ready_i),
    .result_id_o       (bus.result_id_o),
    .result_data_o     (bus.result_data_o),
    .clr_valid_o       (clr_valid),
    .clr_id_o          (clr_id),
    .stray_o           (bus.stray_o),
    .perf_stray_o      (bus.perf_stray_o)
  );

`ifdef CVXIF_ROUTER_PERF_EN
  logic [NumCopro-1:0][31:0] issued_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      issued_q <= '0;
    end else begin
      for (int i = 0; i < NumCopro; i++) begin
        if (issue_hs && bus.issue_accept_o && issue_winner == OwnerWidth'(i))
          issued_q[i] <= issued_q[i] + 32'd1;
      end
    end
  end
  assign bus.perf_issued_o = issued_q;
`else
  assign bus.perf_issued_o = '0;
`endif

endmodule

// File: tb/tb_cvxif_copro_router.sv
// Bench for cvxif_copro_router: directed scenarios plus random traffic, checked
// against an ID-ownership reference model and a result scoreboard queue.
module tb_cvxif_copro_router;
  localparam int N     = 2;
  localparam int IW    = 3;
  localparam int XL    = 64;
  localparam int INW   = 32;
  localparam int DEPTH = 8;

  logic clk, rst_n;

  cvxif_copro_router_if #(.NumCopro(N), .IdWidth(IW), .XLEN(XL), .InstrWidth(INW)) bus();

  cvxif_copro_router #(.NumCopro(N), .IdWidth(IW), .XLEN(XL), .InstrWidth(INW)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: run did not complete in time");
    $fatal(1, "watchdog expired");
  end

  int n_vec = 0;
  int n_err = 0;

  // reference model: owner of each ID (-1 = free), next round-robin lane,
  // whether the core-facing result slot is occupied, counters
  int          owner[DEPTH];
  int          rr_next;
  bit          out_full;
  bit          exp_multi, exp_stray;
  int unsigned stray_total;
  int unsigned issued[N];
  logic [IW+XL-1:0] exp_q[$];
  logic [IW+XL-1:0] item;

  // per-lane result drivers: hold until the router takes them
  bit             lane_on[N];
  logic [IW-1:0]  lane_id[N];
  logic [XL-1:0]  lane_data[N];
  int             own[4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit any_lane();
    bit a = 0;
    for (int i = 0; i < N; i++) a = a | lane_on[i];
    return a;
  endfunction

  function automatic logic [N-1:0] lane_mask(input int l);
    logic [N-1:0] m = '0;
    m[l] = 1'b1;
    return m;
  endfunction

  task automatic model_reset();
    foreach (owner[i]) owner[i] = -1;
    rr_next = 0; out_full = 0; exp_multi = 0; exp_stray = 0; stray_total = 0;
    foreach (issued[i]) issued[i] = 0;
    exp_q.delete();
  endtask

  task automatic zero_inputs();
    bus.flush_i = 0; bus.issue_valid_i = 0; bus.issue_id_i = '0; bus.issue_instr_i = '0;
    bus.cp_issue_ready_i = '0; bus.cp_issue_accept_i = '0; bus.cp_issue_writeback_i = '0;
    bus.cp_result_valid_i = '0; bus.cp_result_id_i = '0; bus.cp_result_data_i = '0;
    bus.result_ready_i = 0;
    foreach (lane_on[i]) lane_on[i] = 0;
  endtask

  task automatic check_perf();
`ifdef CVXIF_ROUTER_PERF_EN
    check("perf_stray", bus.perf_stray_o, stray_total);
    for (int i = 0; i < N; i++) check("perf_issued", bus.perf_issued_o[i*32 +: 32], issued[i]);
`else
    check("perf_stray", bus.perf_stray_o, 0);
    check("perf_issued", bus.perf_issued_o, 0);
`endif
  endtask

  // One clock: check combinational outputs before the edge, advance the model
  // across the edge, then check registered outputs just after it.
  task automatic step();
    logic [N-1:0] acc, cand, stray, exp_rdy, v_exp;
    bit ok, hs, load, wb_w, busy_exp;
    int acc_w, win, j;
    for (int i = 0; i < N; i++) begin
      bus.cp_result_valid_i[i]          = lane_on[i];
      bus.cp_result_id_i[i*IW +: IW]    = lane_id[i];
      bus.cp_result_data_i[i*XL +: XL]  = lane_data[i];
    end
    @(negedge clk);
    ok    = (owner[bus.issue_id_i] < 0) && !bus.flush_i;
    v_exp = (bus.issue_valid_i && ok) ? '1 : '0;
    check("issue_ready", bus.issue_ready_o, (&bus.cp_issue_ready_i) && ok);
    check("cp_issue_valid", bus.cp_issue_valid_o, v_exp);
    check("cp_issue_id", bus.cp_issue_id_o, bus.issue_id_i);
    acc   = bus.cp_issue_accept_i;
    acc_w = -1;
    for (int i = N - 1; i >= 0; i--) if (acc[i]) acc_w = i;
    wb_w = 0;
    for (int i = 0; i < N; i++) if (i == acc_w) wb_w = bus.cp_issue_writeback_i[i];
    check("issue_accept", bus.issue_accept_o, (acc_w >= 0));
    check("issue_writeback", bus.issue_writeback_o, wb_w);
    for (int i = 0; i < N; i++) begin
      cand[i]  = lane_on[i] && (owner[lane_id[i]] == i);
      stray[i] = lane_on[i] && !cand[i];
    end
    load = (!out_full || bus.result_ready_i) && !bus.flush_i;
    win  = -1;
    if (load) begin
      for (int k = 0; k < N; k++) begin
        j = (rr_next + k) % N;
        if (win < 0 && cand[j]) win = j;
      end
    end
    exp_rdy = stray;
    if (win >= 0) exp_rdy = exp_rdy | lane_mask(win);
    check("cp_result_ready", bus.cp_result_ready_o, exp_rdy);
    hs = bus.issue_valid_i && (&bus.cp_issue_ready_i) && ok;
    @(posedge clk);
    exp_multi = hs && ($countones(acc) > 1);
    if (hs && acc_w >= 0) begin
      issued[acc_w]++;
      if (wb_w) owner[bus.issue_id_i] = acc_w;
    end
    exp_stray    = |stray;
    stray_total += $countones(stray);
    if (bus.flush_i) begin
      foreach (owner[i]) owner[i] = -1;
      if (out_full && !bus.result_ready_i && exp_q.size() > 0) exp_q.delete(exp_q.size() - 1);
      out_full = 0;
    end else if (load) begin
      if (win >= 0) begin
        owner[lane_id[win]] = -1;
        exp_q.push_back({lane_id[win], lane_data[win]});
        rr_next  = (win + 1) % N;
        out_full = 1;
      end else begin
        out_full = 0;
      end
    end
    for (int i = 0; i < N; i++) if (exp_rdy[i]) lane_on[i] = 0;
    #1;
    busy_exp = 0;
    foreach (owner[i]) if (owner[i] >= 0) busy_exp = 1;
    check("multi_accept", bus.multi_accept_o, exp_multi);
    check("stray", bus.stray_o, exp_stray);
    check("busy", bus.busy_o, busy_exp);
    check("result_valid", bus.result_valid_o, out_full);
    check_perf();
  endtask

  // driver tasks
  task automatic issue(input int id, input logic [N-1:0] acc, input logic [N-1:0] wb);
    bus.issue_valid_i        = 1;
    bus.issue_id_i           = IW'(id);
    bus.issue_instr_i        = $urandom;
    bus.cp_issue_ready_i     = '1;
    bus.cp_issue_accept_i    = acc;
    bus.cp_issue_writeback_i = wb;
    step();
    bus.issue_valid_i        = 0;
    bus.cp_issue_accept_i    = '0;
    bus.cp_issue_writeback_i = '0;
  endtask

  task automatic send(input int lane, input int id, input logic [XL-1:0] data);
    lane_on[lane]   = 1;
    lane_id[lane]   = IW'(id);
    lane_data[lane] = data;
  endtask

  task automatic wait_lanes(input int max);
    int c = 0;
    while (any_lane() && c < max) begin step(); c++; end
    check("lanes_taken", any_lane(), 0);
  endtask

  task automatic drain(input int max);
    int c = 0;
    bus.result_ready_i = 1;
    while ((any_lane() || out_full) && c < max) begin step(); c++; end
    check("drained", any_lane() || out_full, 0);
  endtask

  task automatic do_reset();
    zero_inputs();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_result_valid", bus.result_valid_o, 0);
    check("rst_result_data", bus.result_data_o, 0);
    check("rst_busy", bus.busy_o, 0);
    check("rst_stray", bus.stray_o, 0);
    check("rst_multi", bus.multi_accept_o, 0);
    check("rst_issue_ready", bus.issue_ready_o, 0);
    rst_n = 1;
    model_reset();
    bus.cp_issue_ready_i = '1;
  endtask

  // scoreboard monitor: pops on every core-side result handshake
  always @(negedge clk) begin
    if (rst_n && bus.result_valid_o && bus.result_ready_i) begin
      check("result_pending", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        item = exp_q.pop_front();
        check("result_id", bus.result_id_o, item[IW+XL-1:XL]);
        check("result_data", bus.result_data_o, item[XL-1:0]);
      end
    end
  end

  initial begin
    do_reset();

    // basic offload and writeback
    issue(3, 2'b10, 2'b10);
    send(1, 3, 64'hDEAD);
    drain(20);

    // double accept: lane 0 owns ID 2, lane 1 result is stray
    issue(2, 2'b11, 2'b11);
    step();
    send(1, 2, {$urandom, $urandom});
    drain(20);
    send(0, 2, {$urandom, $urandom});
    drain(20);

    // fairness: both lanes return results repeatedly
    for (int r = 0; r < 4; r++) begin
      issue(4, 2'b01, 2'b01);
      issue(5, 2'b10, 2'b10);
      send(0, 4, {$urandom, $urandom});
      send(1, 5, {$urandom, $urandom});
      drain(20);
    end

    // reissue of an outstanding ID is blocked until its result loads
    issue(6, 2'b01, 2'b01);
    bus.issue_valid_i = 1; bus.issue_id_i = 3'd6;
    bus.cp_issue_accept_i = 2'b01; bus.cp_issue_writeback_i = 2'b01;
    repeat (2) step();
    bus.issue_valid_i = 0; bus.cp_issue_accept_i = '0; bus.cp_issue_writeback_i = '0;
    send(0, 6, {$urandom, $urandom});
    drain(20);
    issue(6, 2'b10, 2'b10);
    send(1, 6, {$urandom, $urandom});
    drain(20);

    // flush with IDs outstanding and a held output
    do_reset();
    for (int id = 0; id < 4; id++) begin
      own[id] = $urandom_range(0, N - 1);
      issue(id, lane_mask(own[id]), lane_mask(own[id]));
    end
    bus.result_ready_i = 0;
    send(own[0], 0, {$urandom, $urandom});
    wait_lanes(10);
    step();
    bus.flush_i = 1;
    step();
    bus.flush_i = 0;
    for (int id = 1; id < 4; id++) begin
      send(own[id], id, {$urandom, $urandom});
      wait_lanes(10);
    end
    step();
    drain(20);

    // async reset during a stalled output; pointer must restart at lane 0
    issue(1, 2'b01, 2'b01);
    bus.result_ready_i = 0;
    send(0, 1, {$urandom, $urandom});
    wait_lanes(10);
    step();
    zero_inputs();
    #3;
    rst_n = 0;
    #1;
    check("arst_result_valid", bus.result_valid_o, 0);
    check("arst_result_id", bus.result_id_o, 0);
    check("arst_busy", bus.busy_o, 0);
    check("arst_perf_stray", bus.perf_stray_o, 0);
    check("arst_perf_issued", bus.perf_issued_o, 0);
    @(posedge clk);
    #1;
    rst_n = 1;
    model_reset();
    bus.cp_issue_ready_i = '1;
    issue(4, 2'b01, 2'b01);
    issue(5, 2'b10, 2'b10);
    send(0, 4, {$urandom, $urandom});
    send(1, 5, {$urandom, $urandom});
    drain(20);

    // random traffic
    for (int c = 0; c < 400; c++) begin
      bus.issue_valid_i        = $urandom_range(0, 1);
      bus.issue_id_i           = IW'($urandom_range(0, DEPTH - 1));
      bus.issue_instr_i        = $urandom;
      bus.cp_issue_ready_i     = ($urandom_range(0, 5) == 0) ? N'($urandom) : '1;
      bus.cp_issue_accept_i    = N'($urandom);
      bus.cp_issue_writeback_i = N'($urandom);
      for (int l = 0; l < N; l++) begin
        if (!lane_on[l] && $urandom_range(0, 2) == 0) begin
          int ids[$];
          for (int d = 0; d < DEPTH; d++) if (owner[d] == l) ids.push_back(d);
          if (ids.size() > 0 && $urandom_range(0, 3) != 0)
            send(l, ids[$urandom_range(0, ids.size() - 1)], {$urandom, $urandom});
          else
            send(l, $urandom_range(0, DEPTH - 1), {$urandom, $urandom});
        end
      end
      bus.result_ready_i = ($urandom_range(0, 3) != 0);
      bus.flush_i        = ($urandom_range(0, 40) == 0);
      step();
    end
    bus.issue_valid_i = 0;
    bus.flush_i       = 0;
    drain(50);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
